// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and its helpers.
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_TIMEOUT
  } meter_state_t;

  // Consecutive in-tolerance measurements needed before lock is declared.
  localparam int unsigned LOCK_STREAK = 2;
  localparam int unsigned STREAK_W    = $clog2(LOCK_STREAK + 1);

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchronizer followed by a registered edge detector.
// rise/fall pulse for one cycle, three clocks after the input transition.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sigAsync,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= sigAsync;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
      fall  <= ~sync2 & sync3;
    end
  end

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles,
// with loss-of-signal timeout and lock against an expected period.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned EXPECTED_PERIOD = 20000000,
  parameter int unsigned TOLERANCE       = 1000,
  parameter int unsigned TIMEOUT         = 40000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] EXP_P    = WIDTH'(EXPECTED_PERIOD);
  localparam logic [WIDTH-1:0] TOL      = WIDTH'(TOLERANCE);

  logic                rise;
  logic                fall;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    hiReg;
  logic [STREAK_W-1:0] streak;
  meter_state_t        state;
  meter_state_t        stateNext;

  logic [WIDTH-1:0]    newPeriod_c;
  logic [WIDTH-1:0]    diff_c;
  logic                inTol_c;
  logic                publish_c;
  logic                enterTimeout_c;
  logic                leaveTimeout_c;
  logic [STREAK_W-1:0] streakNext_c;
  logic                lockNow_c;

  sync_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .sigAsync (sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  assign newPeriod_c = cnt + WIDTH'(1);

  // Interval counter restarts on each rise and saturates at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      hiReg <= '0;
    end else begin
      if (rise) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + WIDTH'(1);
      end
      if (fall) begin
        hiReg <= newPeriod_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A rise always wins over an expiring count.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (rise) stateNext = ST_MEASURE;
      ST_MEASURE: if (!rise && (cnt == CNT_LAST)) stateNext = ST_TIMEOUT;
      ST_TIMEOUT: if (rise) stateNext = ST_MEASURE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    publish_c      = 1'b0;
    enterTimeout_c = 1'b0;
    leaveTimeout_c = 1'b0;
    case (state)
      ST_MEASURE: begin
        publish_c      = rise;
        enterTimeout_c = !rise && (cnt == CNT_LAST);
      end
      ST_TIMEOUT: leaveTimeout_c = rise;
      default: ;
    endcase

    diff_c       = (newPeriod_c > EXP_P) ? (newPeriod_c - EXP_P) : (EXP_P - newPeriod_c);
    inTol_c      = (diff_c <= TOL);
    streakNext_c = streak;
    if (streak != STREAK_W'(LOCK_STREAK)) begin
      streakNext_c = streak + STREAK_W'(1);
    end
    lockNow_c = (streakNext_c == STREAK_W'(LOCK_STREAK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
      streak     <= '0;
    end else begin
      meas_valid <= publish_c;
      if (publish_c) begin
        period    <= newPeriod_c;
        high_time <= hiReg;
        if (inTol_c) begin
          streak <= streakNext_c;
          locked <= lockNow_c;
        end else begin
          streak <= '0;
          locked <= 1'b0;
        end
      end
      if (enterTimeout_c) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
        streak  <= '0;
      end
      if (leaveTimeout_c) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: table of waveform segments, each with the
// expected result of the rise that starts it, plus hand-built timeout/reset runs.
module tb_period_meter;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        meas_valid;
  logic        timeout;
  logic        locked;

  period_meter #(
    .WIDTH           (32),
    .EXPECTED_PERIOD (20),
    .TOLERANCE       (1),
    .TIMEOUT         (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .locked     (locked)
  );

  typedef struct {
    int hi;
    int lo;
    bit expValid;
    int expPeriod;
    int expHigh;
    bit expLocked;
    bit expTimeout;
  } vec_t;

  vec_t vecs [18];
  int   checkAt [int];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   pulseCnt = 0;
  int   expPulses = 0;
  int   lastRise = 0;
  int   chkIdx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Results of a rise appear four clocks after sig_in goes high.
  always begin
    @(posedge clk);
    #1;
    if (meas_valid) pulseCnt++;
    if (checkAt.exists(cyc)) begin
      chkIdx = checkAt[cyc];
      checkAt.delete(cyc);
      checkVal($sformatf("v%0d meas_valid", chkIdx), meas_valid, vecs[chkIdx].expValid);
      checkVal($sformatf("v%0d period", chkIdx), period, vecs[chkIdx].expPeriod);
      checkVal($sformatf("v%0d high_time", chkIdx), high_time, vecs[chkIdx].expHigh);
      checkVal($sformatf("v%0d locked", chkIdx), locked, vecs[chkIdx].expLocked);
      checkVal($sformatf("v%0d timeout", chkIdx), timeout, vecs[chkIdx].expTimeout);
    end
  end

  task automatic applyWave(input int i);
    sig_in = 1'b1;
    lastRise = cyc;
    checkAt[cyc + 4] = i;
    expPulses += int'(vecs[i].expValid);
    repeat (vecs[i].hi) @(posedge clk);
    #1;
    sig_in = 1'b0;
    repeat (vecs[i].lo) @(posedge clk);
    #1;
  endtask

  task automatic runVecs(input int first, input int last);
    for (int i = first; i <= last; i++) applyWave(i);
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " period"}, period, 0);
    checkVal({tag, " high_time"}, high_time, 0);
    checkVal({tag, " meas_valid"}, meas_valid, 0);
    checkVal({tag, " timeout"}, timeout, 0);
    checkVal({tag, " locked"}, locked, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           hi  lo  val per hi  lock to
    vecs[0]  = '{10, 10, 0,  0,  0, 0, 0};   // first rise after reset
    vecs[1]  = '{10, 10, 1, 20, 10, 0, 0};
    vecs[2]  = '{10, 10, 1, 20, 10, 1, 0};
    vecs[3]  = '{ 9, 10, 1, 20, 10, 1, 0};
    vecs[4]  = '{10, 11, 1, 19,  9, 1, 0};
    vecs[5]  = '{12, 13, 1, 21, 10, 1, 0};
    vecs[6]  = '{10, 10, 1, 25, 12, 0, 0};   // out of tolerance drops lock
    vecs[7]  = '{10, 10, 1, 20, 10, 0, 0};
    vecs[8]  = '{10, 10, 1, 20, 10, 1, 0};
    vecs[9]  = '{10, 10, 0, 20, 10, 0, 0};   // rise out of timeout
    vecs[10] = '{10, 10, 1, 20, 10, 0, 0};
    vecs[11] = '{ 1,  2, 1, 20, 10, 1, 0};
    vecs[12] = '{ 1,  2, 1,  3,  1, 0, 0};
    vecs[13] = '{ 1,  2, 1,  3,  1, 0, 0};
    vecs[14] = '{ 1,  2, 1,  3,  1, 0, 0};
    vecs[15] = '{10, 10, 1,  3,  1, 0, 0};
    vecs[16] = '{10, 10, 1, 20, 10, 0, 0};
    vecs[17] = '{10, 10, 1, 20, 10, 1, 0};

    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    runVecs(0, 8);

    // Signal held low: timeout fires 64 cycles after the last published rise.
    waitCyc(lastRise + 67);
    checkVal("pre-timeout timeout", timeout, 0);
    checkVal("pre-timeout locked", locked, 1);
    waitCyc(lastRise + 68);
    checkVal("timeout asserted", timeout, 1);
    checkVal("timeout locked", locked, 0);
    checkVal("timeout period hold", period, 20);
    checkVal("timeout high_time hold", high_time, 10);
    waitCyc(lastRise + 120);
    checkVal("timeout still set", timeout, 1);
    checkVal("timeout period still held", period, 20);

    runVecs(9, 17);

    // Asynchronous reset in the middle of a locked period.
    repeat (2) @(posedge clk);
    #2;
    checkVal("pre-reset locked", locked, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    runVecs(0, 2);

    repeat (10) @(posedge clk);
    #1;
    checkVal("meas_valid pulse count", pulseCnt, expPulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
